zero_test_arbiter: RTL and testbench
====================================

Name: zero_test_arbiter

Overview:
- Shares a single WIDTH-bit subtract + zero-detect unit between two requesters in the pipelined CPU, e.g. the CBZ/branch resolver (port 0) and the compare/flag-setting path (port 1).
- Round-robin arbitration selects one request per cycle, computes a − b, and holds the result in a one-entry output stage.
- The result is returned on the owning port under valid/ready handshake, with backpressure and flush.

Parameters:
- WIDTH, 16, operand/result width in bits (≥2).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline flush; discards the stage result and blocks grants this cycle.
- req_valid  input  2  per-requester request valid (bit i = requester i).
- req_ready  output  2  per-requester grant; a transfer occurs when req_valid[i] & req_ready[i].
- op_a0, op_b0  input  WIDTH each  requester 0 operands.
- op_a1, op_b1  input  WIDTH each  requester 1 operands.
- resp_valid  output  2  one-hot: result valid for requester i; 0 when stage empty.
- resp_ready  input  2  per-requester result accept.
- resp_diff  output  WIDTH  registered a − b, modulo 2^WIDTH.
- resp_zero  output  1  registered: resp_diff == 0.
- resp_neg  output  1  registered: resp_diff[WIDTH-1].
- resp_borrow  output  1  registered: unsigned a < b.

Behaviour:
- State: stage_valid, stage_owner (1 bit), prio pointer (1 bit), registered result fields.
- Reset (reset=1 at a clk edge): stage_valid=0, stage_owner=0, prio=0, resp_diff=0, resp_zero=0, resp_neg=0, resp_borrow=0. Outputs are then resp_valid=00 and req_ready=00. Reset overrides flush and all requests. Reset mid-transaction drops any held result without a response.
- Stage FSM:
  - EMPTY (stage_valid=0) → FULL on grant.
  - FULL → EMPTY when resp_valid[owner] & resp_ready[owner] and no new grant.
  - FULL → FULL when the result is accepted and a new grant occurs in the same cycle (back-to-back, one result per cycle).
  - FULL holds while the owner's resp_ready=0. resp_ready of the non-owner is ignored.
- can_issue = !flush & (!stage_valid | resp_ready[stage_owner]).
- Arbitration, combinational, only when can_issue:
  - Only one req_valid → grant it.
  - Both valid → grant requester prio.
  - At most one req_ready bit is high; req_ready=00 when !can_issue or no req_valid.
  - req_ready may depend on req_valid, not vice versa; requesters hold operands stable while valid.
- Pointer update on a grant to i: prio ← ~i. No grant → prio unchanged.
- Compute on grant edge, from the granted port's operands:
  - diff = (a − b) mod 2^WIDTH.
  - zero = (diff == 0).
  - neg = diff[WIDTH-1].
  - borrow = carry-out of a + ~b + 1 inverted, i.e. unsigned a < b.
  - stage_owner ← i, stage_valid ← 1.
- Latency: request accepted at edge N → resp_valid asserted after edge N, i.e. visible in cycle N+1. Throughput: 1 op/cycle with resp_ready held high.
- resp_valid = stage_valid ? (1 << stage_owner) : 00.
- Result fields hold their value while FULL and after draining; they change only on a grant or reset.
- Flush (reset=0): stage_valid ← 0, no grant that cycle, prio unchanged, result fields unchanged. A response accepted in the same cycle as flush counts as consumed, with no duplicate. Flush while EMPTY has no effect.
- Boundaries:
  - a == b → zero=1, borrow=0.
  - 0 − 1 → diff=all ones, neg=1, borrow=1.
  - 0x8000 − 1 (WIDTH=16) → diff=0x7FFF, neg=0, borrow=0.

Test Plan:
- Reset: hold reset 2 cycles with req_valid=11 → req_ready=00, resp_valid=00, resp_diff=0, flags 0; first grant after reset goes to requester 0.
- Single op: port 0, a=0x1234, b=0x1234 → cycle+1: resp_valid=01, resp_diff=0x0000, zero=1, neg=0, borrow=0. Port 1, a=0x0000, b=0x0001 → resp_valid=10, diff=0xFFFF, zero=0, neg=1, borrow=1.
- Fairness: both ports valid continuously with resp_ready=11 for 6 cycles → grant order 0,1,0,1,0,1; one response per cycle, each on the correct port with the correct diff.
- Backpressure: port 0 result held with resp_ready=00 for 3 cycles while port 1 requests → req_ready=00 throughout, result fields stable. Raise resp_ready[0] → same-cycle grant to port 1; its result appears the next cycle.
- Flush: stage FULL for port 1 (a=5, b=3, diff=0x0002) with resp_ready=00, pulse flush with req_valid=01 → no grant that cycle, next cycle resp_valid=00, then port 0 granted; prio unchanged by the flush.
- Reset mid-op: stage FULL, assert reset → next cycle resp_valid=00, prio=0, no stale response delivered afterward.

Source files
------------

// File: rtl/zero_test_arbiter.sv
// zero_test_arbiter
// A single WIDTH-bit subtract and zero-detect unit shared between two requesters,
// for example the branch resolver (port 0) and the flag-setting compare path
// (port 1). Each cycle a round-robin arbiter picks at most one request and
// computes a - b. The result sits in a one-entry output stage until the owning
// port accepts it under a valid/ready handshake. Flush empties the stage and
// blocks issue for that cycle.

module zero_test_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] op_a0,
  input  logic [WIDTH-1:0] op_b0,
  input  logic [WIDTH-1:0] op_a1,
  input  logic [WIDTH-1:0] op_b1,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [WIDTH-1:0] resp_diff,
  output logic             resp_zero,
  output logic             resp_neg,
  output logic             resp_borrow
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stageState_t;

  stageState_t      stageState;
  logic             stageOwner;
  logic             prio;

  logic             canIssue;
  logic             grantValid;
  logic             grantIdx;
  logic [WIDTH-1:0] selA;
  logic [WIDTH-1:0] selB;
  logic [WIDTH-1:0] nextDiff;
  logic             carryOut;

  // Issue is allowed when the stage is free or is being drained this cycle.
  always_comb begin
    canIssue = !reset && !flush &&
               ((stageState == EMPTY) || resp_ready[stageOwner]);
  end

  // Round-robin grant: a lone request wins outright, a tie goes to prio.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves a value unassigned and infers a latch.
    grantValid = 1'b0;
    grantIdx   = 1'b0;
    if (canIssue) begin
      case (req_valid)
        2'b01: begin
          grantValid = 1'b1;
          grantIdx   = 1'b0;
        end
        2'b10: begin
          grantValid = 1'b1;
          grantIdx   = 1'b1;
        end
        2'b11: begin
          grantValid = 1'b1;
          grantIdx   = prio;
        end
        default: begin
          grantValid = 1'b0;
          grantIdx   = 1'b0;
        end
      endcase
    end
    req_ready = grantValid ? (grantIdx ? 2'b10 : 2'b01) : 2'b00;
  end

  // Operand select and subtract as a + ~b + 1; a missing carry-out means a < b.
  always_comb begin
    selA = grantIdx ? op_a1 : op_a0;
    selB = grantIdx ? op_b1 : op_b0;
    {carryOut, nextDiff} = {1'b0, selA} + {1'b0, ~selB} + (WIDTH + 1)'(1);
  end

  // Result is presented one-hot on the owning port whenever the stage is full.
  always_comb begin
    resp_valid = (stageState == FULL) ? (stageOwner ? 2'b10 : 2'b01) : 2'b00;
  end

  // Stage FSM, priority pointer and registered result fields.
  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignment so every register samples
    // the pre-edge values, independent of statement order.
    if (reset) begin
      // NOTE: the result registers are reset too, because they are directly
      // visible on the outputs and must read as zero after reset.
      stageState  <= EMPTY;
      stageOwner  <= 1'b0;
      prio        <= 1'b0;
      resp_diff   <= '0;
      resp_zero   <= 1'b0;
      resp_neg    <= 1'b0;
      resp_borrow <= 1'b0;
    end else if (flush) begin
      // Flush drops the held result; pointer and result fields are untouched.
      stageState <= EMPTY;
    end else begin
      case (stageState)
        EMPTY: begin
          if (grantValid) begin
            stageState <= FULL;
          end
        end
        FULL: begin
          if (!grantValid && resp_ready[stageOwner]) begin
            stageState <= EMPTY;
          end
        end
        default: stageState <= EMPTY;
      endcase

      if (grantValid) begin
        stageOwner  <= grantIdx;
        prio        <= ~grantIdx;
        resp_diff   <= nextDiff;
        resp_zero   <= (nextDiff == '0);
        resp_neg    <= nextDiff[WIDTH-1];
        resp_borrow <= ~carryOut;
      end
    end
  end

endmodule

// File: tb/tb_zero_test_arbiter.sv
// tb_zero_test_arbiter
// Scoreboarded bench for zero_test_arbiter. An issue observer predicts grants
// from the arbitration rules and pushes the arithmetic result of every grant
// into a queue. A separate monitor pops and compares that entry when the
// owning port accepts it, or discards it on flush. Directed scenarios come
// first, followed by a long randomized phase.

module tb_zero_test_arbiter;

  localparam int W = 16;

  typedef struct {
    bit         port;
    logic [W-1:0] diff;
    bit         zero;
    bit         neg;
    bit         borrow;
  } result_t;

  logic         clk;
  logic         reset;
  logic         flush;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] op_a0, op_b0, op_a1, op_b1;
  logic [1:0]   resp_valid;
  logic [1:0]   resp_ready;
  logic [W-1:0] resp_diff;
  logic         resp_zero, resp_neg, resp_borrow;

  int checks = 0;
  int errors = 0;
  result_t sb[$];

  zero_test_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op_a0      (op_a0),
    .op_b0      (op_b0),
    .op_a1      (op_a1),
    .op_b1      (op_b1),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_diff  (resp_diff),
    .resp_zero  (resp_zero),
    .resp_neg   (resp_neg),
    .resp_borrow(resp_borrow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference result of a subtraction, straight from plain arithmetic.
  function automatic result_t expected(input bit port, input logic [W-1:0] a, input logic [W-1:0] b);
    result_t r;
    r.port   = port;
    r.diff   = a - b;
    r.zero   = (a == b);
    r.neg    = r.diff[W-1];
    r.borrow = (a < b);
    return r;
  endfunction

  // Issue observer: predicts req_ready from the arbitration rules and records
  // the expected result of every grant.
  initial begin : issue_observer
    bit mFull, mOwner, mPrio, gv, g;
    logic [1:0] expReady;
    result_t item;
    mFull = 0; mOwner = 0; mPrio = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("req_ready_in_reset", req_ready, 2'b00);
        mFull = 0; mOwner = 0; mPrio = 0;
      end else begin
        gv = 0; g = 0;
        if (!flush && (!mFull || resp_ready[mOwner])) begin
          if (req_valid == 2'b11) begin gv = 1; g = mPrio; end
          else if (req_valid == 2'b01) begin gv = 1; g = 0; end
          else if (req_valid == 2'b10) begin gv = 1; g = 1; end
        end
        expReady = gv ? (g ? 2'b10 : 2'b01) : 2'b00;
        check("req_ready", req_ready, expReady);
        if (gv) begin
          item = g ? expected(1'b1, op_a1, op_b1) : expected(1'b0, op_a0, op_b0);
          mPrio = !g; mFull = 1; mOwner = g;
          #1 sb.push_back(item);
        end else if (flush) begin
          mFull = 0;
        end else if (mFull && resp_ready[mOwner]) begin
          mFull = 0;
        end
      end
    end
  end

  // Response monitor: the queue head is the result the stage should hold.
  initial begin : response_monitor
    logic [1:0] expValid;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
      end else begin
        expValid = (sb.size() == 0) ? 2'b00 : (sb[0].port ? 2'b10 : 2'b01);
        check("resp_valid", resp_valid, expValid);
        if (sb.size() != 0) begin
          check("resp_diff", resp_diff, sb[0].diff);
          check("resp_zero", resp_zero, sb[0].zero);
          check("resp_neg", resp_neg, sb[0].neg);
          check("resp_borrow", resp_borrow, sb[0].borrow);
          if (resp_ready[sb[0].port] || flush) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic new_ops(input int port);
    logic [W-1:0] a, b;
    int sel;
    sel = $urandom_range(0, 7);
    a = W'($urandom);
    b = W'($urandom);
    if (sel == 0) b = a;
    else if (sel == 1) begin a = '0; b = W'(1); end
    else if (sel == 2) begin a = W'(16'h8000); b = W'(1); end
    if (port == 0) begin op_a0 = a; op_b0 = b; end
    else begin op_a1 = a; op_b1 = b; end
  endtask

  initial begin : stimulus
    logic [1:0] granted;
    reset = 1; flush = 0; req_valid = 2'b11; resp_ready = 2'b11;
    op_a0 = 16'h1234; op_b0 = 16'h1234; op_a1 = 16'h0000; op_b1 = 16'h0001;

    // Reset held for two edges with both requesters active.
    tick(); tick();
    @(negedge clk);
    check("rst_resp_valid", resp_valid, 2'b00);
    check("rst_diff", resp_diff, 16'h0000);
    check("rst_zero", resp_zero, 1'b0);
    check("rst_neg", resp_neg, 1'b0);
    check("rst_borrow", resp_borrow, 1'b0);
    check("rst_req_ready", req_ready, 2'b00);
    tick(); reset = 0;

    // Single ops on each port, including a == b and 0 - 1.
    @(negedge clk); check("first_grant", req_ready, 2'b01);
    tick(); req_valid = 2'b10;
    @(negedge clk);
    check("p0_resp_valid", resp_valid, 2'b01);
    check("p0_zero", resp_zero, 1'b1);
    check("p0_borrow", resp_borrow, 1'b0);
    tick(); req_valid = 2'b00;
    @(negedge clk);
    check("p1_resp_valid", resp_valid, 2'b10);
    check("p1_diff", resp_diff, 16'hFFFF);
    check("p1_neg", resp_neg, 1'b1);
    check("p1_borrow", resp_borrow, 1'b1);
    tick();

    // Fairness with both ports requesting continuously.
    op_a0 = 16'h00FF; op_b0 = 16'h0F0F; op_a1 = 16'hFFFF; op_b1 = 16'hFFFE;
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("fair_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
    end
    req_valid = 2'b00; tick(); tick();

    // Backpressure: port 0 result held while port 1 waits.
    resp_ready = 2'b00; req_valid = 2'b01; op_a0 = 16'h8000; op_b0 = 16'h0001;
    tick();
    req_valid = 2'b10; op_a1 = 16'h0005; op_b1 = 16'h0003;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_req_ready", req_ready, 2'b00);
      check("bp_diff", resp_diff, 16'h7FFF);
      check("bp_neg", resp_neg, 1'b0);
      check("bp_borrow", resp_borrow, 1'b0);
      tick();
    end
    resp_ready = 2'b01;
    @(negedge clk); check("bp_release_grant", req_ready, 2'b10);
    tick(); resp_ready = 2'b00; req_valid = 2'b00;
    @(negedge clk);
    check("bp_result_valid", resp_valid, 2'b10);
    check("bp_result_diff", resp_diff, 16'h0002);
    tick();

    // Flush while port 1's result is held.
    req_valid = 2'b01; op_a0 = 16'h0007; op_b0 = 16'h0007; flush = 1;
    @(negedge clk); check("flush_no_grant", req_ready, 2'b00);
    tick(); flush = 0;
    @(negedge clk);
    check("flush_resp_valid", resp_valid, 2'b00);
    check("flush_then_grant", req_ready, 2'b01);
    tick(); req_valid = 2'b00; resp_ready = 2'b11;
    tick(); tick();

    // Reset in the middle of a held result.
    resp_ready = 2'b00; req_valid = 2'b01; op_a0 = 16'h0009; op_b0 = 16'h0004;
    tick(); req_valid = 2'b00; reset = 1;
    tick(); reset = 0;
    @(negedge clk);
    check("rstmid_resp_valid", resp_valid, 2'b00);
    tick(); req_valid = 2'b11;
    @(negedge clk); check("rstmid_prio", req_ready, 2'b01);
    tick(); req_valid = 2'b00; resp_ready = 2'b11;
    tick(); tick();

    // Randomized traffic; requesters hold operands until granted.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      granted = reset ? 2'b00 : (req_valid & req_ready);
      tick();
      for (int i = 0; i < 2; i++) begin
        if (granted[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          new_ops(i);
        end
      end
      resp_ready[0] = ($urandom_range(0, 3) != 0);
      resp_ready[1] = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 499) == 0);
    end

    // Drain and confirm nothing is left outstanding.
    reset = 0; flush = 0; req_valid = 2'b00; resp_ready = 2'b11;
    repeat (4) tick();
    @(negedge clk);
    check("drain_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
